router_ingress: RTL and testbench



---
 rtl/router_pkg.sv | 23 ++
 rtl/router_parity_acc.sv | 27 ++
 rtl/router_ingress.sv | 188 ++++++++++++++++++
 tb/tb_router_ingress.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and header field layout for the mini-router ingress stage.
package router_pkg;

  typedef enum logic [2:0] {
    ST_DECODE,
    ST_WAIT_EMPTY,
    ST_LOAD,
    ST_FULL_HOLD,
    ST_CHECK,
    ST_DROP
  } state_e;

  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int DEST_MSB = 1;
  localparam int DEST_LSB = 0;

  localparam int LEN_W  = LEN_MSB - LEN_LSB + 1;
  localparam int DEST_W = DEST_MSB - DEST_LSB + 1;

  localparam int NUM_PORTS_DEF = 3;

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR of accepted packet bytes; clr restarts the sum with the current byte.
module router_parity_acc #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] acc
);

  logic [DATA_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = clr ? '0 : acc_q;
    if (en) acc_d = acc_d ^ din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/router_ingress.sv
// Packet ingress: decodes the header, forwards bytes to one output FIFO, checks length/parity.
// Parity checking is built only when ROUTER_INGRESS_PARITY_EN is defined.
//
//   state         | meaning
//   ST_DECODE     | idle / waiting for a header
//   ST_WAIT_EMPTY | header held until the target FIFO drains
//   ST_LOAD       | forwarding payload, then parity
//   ST_FULL_HOLD  | target FIFO full, source stalled
//   ST_CHECK      | length/parity verdict, pkt_done
//   ST_DROP       | bad destination, swallow the packet
module router_ingress
  import router_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = NUM_PORTS_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [DATA_W-1:0]    data_in,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  output logic                 busy,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic [DATA_W-1:0]    data_out,
  output logic                 ifd_state,
  output logic                 err,
  output logic                 pkt_done
);

  state_e               state_q, state_d;
  logic [DEST_W-1:0]    dest_q, dest_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 ifd_state_q, ifd_state_d;
  logic                 pkt_done_q, pkt_done_d;
  logic [NUM_PORTS-1:0] write_enb_q, write_enb_d;
  logic [DATA_W-1:0]    data_out_q, data_out_d;

  logic [DEST_W-1:0]    hdr_dest;
  logic [LEN_W-1:0]     hdr_len;
  logic [NUM_PORTS-1:0] hdr_sel;
  logic [NUM_PORTS-1:0] dest_sel;
  logic                 hdr_ok;
  logic                 hdr_empty;
  logic                 full_sel;
  logic                 parity_bad;

  assign hdr_dest  = data_in[DEST_MSB:DEST_LSB];
  assign hdr_len   = data_in[LEN_MSB:LEN_LSB];
  // An out-of-range destination shifts the one-hot bit off the end, giving zero.
  assign hdr_sel   = NUM_PORTS'(1) << hdr_dest;
  assign dest_sel  = NUM_PORTS'(1) << dest_q;
  assign hdr_ok    = |hdr_sel;
  assign hdr_empty = |(fifo_empty & hdr_sel);
  assign full_sel  = |(fifo_full & dest_sel);

`ifdef ROUTER_INGRESS_PARITY_EN
  logic              acc_clr;
  logic              acc_en;
  logic [DATA_W-1:0] acc;

  assign acc_clr = (state_q == ST_DECODE) && pkt_valid && hdr_ok && hdr_empty;
  assign acc_en  = acc_clr || ((state_q == ST_LOAD) && !full_sel && pkt_valid);

  router_parity_acc #(.DATA_W(DATA_W)) u_parity_acc (
    .clock (clock),
    .reset (reset),
    .clr   (acc_clr),
    .en    (acc_en),
    .din   (data_in),
    .acc   (acc)
  );

  // In CHECK the parity byte is still sitting in data_out_q.
  assign parity_bad = (acc != data_out_q);
`else
  assign parity_bad = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    dest_d      = dest_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    ifd_state_d = 1'b0;
    pkt_done_d  = 1'b0;
    write_enb_d = '0;
    data_out_d  = data_out_q;
    busy        = 1'b0;

    case (state_q)
      ST_DECODE: begin
        if (pkt_valid) begin
          dest_d = hdr_dest;
          if (!hdr_ok) begin
            err_d   = 1'b1;
            state_d = ST_DROP;
          end else if (hdr_empty) begin
            write_enb_d = hdr_sel;
            data_out_d  = data_in;
            ifd_state_d = 1'b1;
            len_d       = hdr_len;
            cnt_d       = '0;
            err_d       = 1'b0;
            state_d     = ST_LOAD;
          end else begin
            state_d = ST_WAIT_EMPTY;
          end
        end
      end

      ST_WAIT_EMPTY: begin
        busy = 1'b1;
        if (|(fifo_empty & dest_sel)) state_d = ST_DECODE;
      end

      ST_LOAD: begin
        busy = full_sel;
        if (full_sel) begin
          state_d = ST_FULL_HOLD;
        end else begin
          write_enb_d = dest_sel;
          data_out_d  = data_in;
          if (pkt_valid) begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end

      ST_FULL_HOLD: begin
        busy = 1'b1;
        if (!full_sel) state_d = ST_LOAD;
      end

      ST_CHECK: begin
        busy       = 1'b1;
        pkt_done_d = 1'b1;
        if ((cnt_q != len_q) || parity_bad) err_d = 1'b1;
        state_d    = ST_DECODE;
      end

      ST_DROP: begin
        if (!pkt_valid) begin
          pkt_done_d = 1'b1;
          state_d    = ST_DECODE;
        end
      end

      default: state_d = ST_DECODE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_DECODE;
      dest_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      ifd_state_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      write_enb_q <= '0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      ifd_state_q <= ifd_state_d;
      pkt_done_q  <= pkt_done_d;
      write_enb_q <= write_enb_d;
      data_out_q  <= data_out_d;
    end
  end

  assign write_enb = write_enb_q;
  assign data_out  = data_out_q;
  assign ifd_state = ifd_state_q;
  assign err       = err_q;
  assign pkt_done  = pkt_done_q;

endmodule

// File: tb/tb_router_ingress.sv
// Scoreboard bench for router_ingress: packet-level model feeds expected writes/verdicts.
module tb_router_ingress;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic       busy;
  logic [2:0] write_enb;
  logic [7:0] data_out;
  logic       ifd_state;
  logic       err;
  logic       pkt_done;

  router_ingress #(.DATA_W(8), .NUM_PORTS(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .pkt_valid  (pkt_valid),
    .data_in    (data_in),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .busy       (busy),
    .write_enb  (write_enb),
    .data_out   (data_out),
    .ifd_state  (ifd_state),
    .err        (err),
    .pkt_done   (pkt_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] enb;
    logic [7:0] data;
    logic       ifd;
  } wr_t;

  wr_t  wr_q[$];
  logic done_q[$];
  wr_t  wr_e;
  logic done_e;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] pay[64];
  int         empty_left = 0;
  int         full_left  = 0;
  logic [2:0] empty_mask = 3'b000;
  logic [2:0] full_mask  = 3'b000;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a write or a packet verdict.
  always @(negedge clock) begin
    if (!reset) begin
      if (write_enb != 3'b000) begin
        if (wr_q.size() == 0) begin
          chk(1'b0, "unexpected_write", int'({write_enb, data_out}), 0);
        end else begin
          wr_e = wr_q.pop_front();
          chk(write_enb == wr_e.enb,  "write_enb", int'(write_enb), int'(wr_e.enb));
          chk(data_out  == wr_e.data, "data_out",  int'(data_out),  int'(wr_e.data));
          chk(ifd_state == wr_e.ifd,  "ifd_state", int'(ifd_state), int'(wr_e.ifd));
        end
        if (ifd_state) chk(err == 1'b0, "err_clear_on_header", int'(err), 0);
      end
      if (pkt_done) begin
        if (done_q.size() == 0) begin
          chk(1'b0, "unexpected_pkt_done", 1, 0);
        end else begin
          done_e = done_q.pop_front();
          chk(err == done_e, "err_at_pkt_done", int'(err), int'(done_e));
        end
      end
    end
  end

  // Presents one byte and holds it until the DUT takes it (busy low, plus empty target for a header).
  task automatic send_byte(input logic v, input logic [7:0] d, input int empty_port);
    int t;
    t = 0;
    pkt_valid = v;
    data_in   = d;
    forever begin
      fifo_full  = (full_left > 0) ? full_mask : 3'b000;
      fifo_empty = (empty_left > 0) ? ~empty_mask : 3'b111;
      if (full_left > 0)  full_left--;
      if (empty_left > 0) empty_left--;
      @(negedge clock);
      if (!busy && (empty_port < 0 || fifo_empty[empty_port])) begin
        @(posedge clock); #1;
        break;
      end
      @(posedge clock); #1;
      t++;
      if (t > 200) begin
        n_chk++;
        $display("FAIL accept_timeout: byte 0x%0h not taken after %0d cycles", d, t);
        break;
      end
    end
  endtask

  // Reference model: a packet either writes header/payload/parity to its port or is dropped.
  task automatic send_pkt(input logic [7:0] hdr, input int npay, input logic [7:0] flip,
                          input int wait_e, input int full_at, input int full_len);
    int         dest;
    int         len;
    logic [2:0] mask;
    logic [7:0] par;
    logic       exp_err;
    dest = int'(hdr[1:0]);
    len  = int'(hdr[7:2]);
    par  = hdr;
    for (int i = 0; i < npay; i++) par = par ^ pay[i];
    par  = par ^ flip;
    mask = (dest < 3) ? (3'b001 << dest) : 3'b000;
    if (dest < 3) begin
      wr_q.push_back('{enb: mask, data: hdr, ifd: 1'b1});
      for (int i = 0; i < npay; i++) wr_q.push_back('{enb: mask, data: pay[i], ifd: 1'b0});
      wr_q.push_back('{enb: mask, data: par, ifd: 1'b0});
      exp_err = (npay != len);
`ifdef ROUTER_INGRESS_PARITY_EN
      if (flip != 8'h00) exp_err = 1'b1;
`endif
      done_q.push_back(exp_err);
    end else begin
      done_q.push_back(1'b1);
    end
    empty_mask = mask;
    empty_left = (dest < 3) ? wait_e : 0;
    full_mask  = mask;
    send_byte(1'b1, hdr, (dest < 3) ? dest : -1);
    for (int i = 0; i <= npay; i++) begin
      if (i == full_at) full_left = full_len;
      if (i < npay) send_byte(1'b1, pay[i], -1);
      else          send_byte(1'b0, par, -1);
    end
    pkt_valid = 1'b0;
    data_in   = 8'($urandom);
    fifo_full = 3'b000;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      pkt_valid = 1'b0;
      fifo_full = 3'b000;
      @(posedge clock); #1;
    end
  endtask

  int         r_len;
  int         r_dest;
  int         r_np;
  int         r_kind;
  logic [7:0] r_flip;
  int         r_wait;
  int         r_full_at;

  initial begin
    reset      = 1'b1;
    pkt_valid  = 1'b0;
    data_in    = 8'h00;
    fifo_full  = 3'b000;
    fifo_empty = 3'b111;
    #12;
    chk(write_enb == 3'b000, "reset_write_enb", int'(write_enb), 0);
    chk(data_out  == 8'h00,  "reset_data_out",  int'(data_out),  0);
    chk(ifd_state == 1'b0,   "reset_ifd_state", int'(ifd_state), 0);
    chk(err       == 1'b0,   "reset_err",       int'(err),       0);
    chk(pkt_done  == 1'b0,   "reset_pkt_done",  int'(pkt_done),  0);
    chk(busy      == 1'b0,   "reset_busy",      int'(busy),      0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(2);

    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send_pkt(8'h0D, 3, 8'h00, 0, -1, 0);
    idle(2);
    send_pkt(8'h0D, 3, 8'h03, 0, -1, 0);
    idle(2);
    send_pkt(8'h0D, 3, 8'h00, 4, -1, 0);
    idle(2);
    send_pkt(8'h0D, 3, 8'h00, 0, 2, 3);
    idle(2);
    send_pkt(8'h0D, 3, 8'h00, 0, 3, 2);
    idle(1);
    pay[0] = 8'hA5; pay[1] = 8'h3C;
    send_pkt(8'h0B, 2, 8'h00, 0, -1, 0);
    send_pkt(8'h00, 0, 8'h00, 0, -1, 0);
    idle(3);

    // Reset in the middle of a packet: header and first payload are the only writes.
    wr_q.push_back('{enb: 3'b010, data: 8'h09, ifd: 1'b1});
    wr_q.push_back('{enb: 3'b010, data: 8'h5A, ifd: 1'b0});
    empty_left = 0;
    send_byte(1'b1, 8'h09, 1);
    send_byte(1'b1, 8'h5A, -1);
    @(negedge clock); #1;
    reset = 1'b1;
    #1;
    chk(write_enb == 3'b000, "midreset_write_enb", int'(write_enb), 0);
    chk(data_out  == 8'h00,  "midreset_data_out",  int'(data_out),  0);
    chk(busy      == 1'b0,   "midreset_busy",      int'(busy),      0);
    chk(wr_q.size() == 0,    "midreset_writes_seen", wr_q.size(), 0);
    @(posedge clock); @(posedge clock); #1;
    reset     = 1'b0;
    pkt_valid = 1'b0;
    idle(2);
    chk(busy == 1'b0, "post_reset_busy", int'(busy), 0);
    pay[0] = 8'h77;
    send_pkt(8'h06, 1, 8'h00, 0, -1, 0);
    idle(2);

    for (int p = 0; p < 40; p++) begin
      r_len  = $urandom_range(0, 12);
      r_dest = $urandom_range(0, 3);
      r_kind = $urandom_range(0, 7);
      r_np   = r_len;
      if (r_kind == 0) r_np = r_len + 1;
      else if (r_kind == 1 && r_len > 0) r_np = r_len - 1;
      r_flip = (r_kind == 2) ? 8'($urandom_range(1, 255)) : 8'h00;
      r_wait = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
      r_full_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, r_np) : -1;
      for (int i = 0; i < r_np; i++) pay[i] = 8'($urandom);
      send_pkt({r_len[5:0], r_dest[1:0]}, r_np, r_flip, r_wait, r_full_at, $urandom_range(1, 3));
      idle($urandom_range(0, 2));
    end

    idle(6);
    chk(wr_q.size() == 0,   "writes_outstanding", wr_q.size(), 0);
    chk(done_q.size() == 0, "done_outstanding",   done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
